// File: rtl/dram_responder_if.sv
// Cache-to-DRAM word interface: request from the cache controller,
// read data and wait/accept strobe back from the memory side.
interface dram_responder_if;
    logic        dram_cs;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [31:0] dram_din;
    logic [31:0] dram_dout;
    logic        dram_nwait;

    modport master (
        output dram_cs,
        output dram_we,
        output dram_addr,
        output dram_din,
        input  dram_dout,
        input  dram_nwait
    );

    modport slave (
        input  dram_cs,
        input  dram_we,
        input  dram_addr,
        input  dram_din,
        output dram_dout,
        output dram_nwait
    );
endinterface

// File: rtl/dram_responder.sv
// Open-row DRAM endpoint: word storage with activate/precharge wait
// states and periodic refresh behind the cs/we/nwait handshake.
module dram_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int COL_BITS   = 6,
    parameter int T_RCD      = 2,
    parameter int T_RP       = 2,
    parameter int T_RFC      = 4,
    parameter int REF_PERIOD = 256
) (
    input  logic             clk,
    input  logic             rst,
    dram_responder_if.slave  bus
);

    localparam int ROW_W    = ADDR_WIDTH - COL_BITS;
    localparam int MISS_CYC = T_RP + T_RCD;
    localparam int CNT_MAX  = (MISS_CYC > T_RFC) ? MISS_CYC : T_RFC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int REF_W    = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACT,
        S_OPEN,
        S_REF
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              ref_due_q, ref_due_d;
    logic [31:0]       dout_q;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [ROW_W-1:0]      row_in;
    logic                  hit;
    logic                  nwait;
    logic                  accept;
    logic                  ref_wrap;
    logic                  ref_take;
    logic                  unused_addr;

    // Upper address bits alias; byte-offset bits are ignored.
    assign idx         = bus.dram_addr[ADDR_WIDTH+1:2];
    assign row_in      = bus.dram_addr[ADDR_WIDTH+1:COL_BITS+2];
    assign unused_addr = ^{bus.dram_addr[31:ADDR_WIDTH+2], bus.dram_addr[1:0]};
    assign hit         = (row_in == row_q);

    assign accept         = bus.dram_cs & nwait;
    assign bus.dram_nwait = nwait;
    assign bus.dram_dout  = dout_q;

    assign ref_wrap  = (ref_cnt_q == REF_W'(REF_PERIOD - 1));
    assign ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
    assign ref_due_d = ref_wrap | (ref_due_q & ~ref_take);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        nwait    = 1'b0;
        ref_take = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                nwait = !bus.dram_cs;
                if (ref_due_q) begin
                    ref_take = 1'b1;
                    cnt_d    = CNT_W'(T_RFC);
                    state_d  = S_REF;
                end else if (bus.dram_cs) begin
                    row_d   = row_in;
                    cnt_d   = CNT_W'(T_RCD);
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                // Refresh preempts any access; a pending read is still
                // handed over if the initiator is not requesting.
                if (ref_due_q) begin
                    nwait    = !bus.dram_cs;
                    ref_take = 1'b1;
                    cnt_d    = CNT_W'(T_RFC);
                    state_d  = S_REF;
                end else if (bus.dram_cs && !hit) begin
                    row_d   = row_in;
                    cnt_d   = CNT_W'(MISS_CYC);
                    state_d = S_ACT;
                end else begin
                    nwait = 1'b1;
                end
            end
            S_REF: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            ref_cnt_q <= '0;
            ref_due_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            ref_cnt_q <= ref_cnt_d;
            ref_due_q <= ref_due_d;
            if (accept && !bus.dram_we) begin
                dout_q <= mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept && bus.dram_we) begin
            mem[idx] <= bus.dram_din;
        end
    end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Memory-side responder for the cache-to-DRAM word interface (dram_cs/we/addr/din/dout/nwait).
- Sits where the external DRAM sits and presents the same handshake the cache controller drives as initiator.
- Models an open-row DRAM with word storage, activation/precharge wait states, and periodic refresh.
- Serves as the synthesizable DRAM endpoint for system simulation and FPGA builds.

Parameters:
ADDR_WIDTH, 14, word-index bits; storage depth 2**ADDR_WIDTH 32-bit words
COL_BITS, 6, column bits per row; a row is 2**COL_BITS words
T_RCD, 2, activate cycles (nwait low) before an opened row accepts accesses
T_RP, 2, extra precharge cycles added on a row miss
T_RFC, 4, refresh duration in cycles
REF_PERIOD, 256, cycles between refresh requests

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
dram_cs  input  1  request valid
dram_we  input  1  1 = write, 0 = read
dram_addr  input  32  byte address, word aligned
dram_din  input  32  write data
dram_dout  output  32  read data of the most recently accepted read
dram_nwait  output  1  1 = request accepted this edge and previous read data delivered

Behaviour:
- Handshake: a request is accepted on an edge where dram_cs=1 and dram_nwait=1. Data for an accepted read is registered into dram_dout on its accept edge and held until the next accepted read. The initiator consumes it on the next edge with dram_nwait=1, whether or not a new request is present. At most one request per edge.
- Word index = dram_addr[ADDR_WIDTH+1:2]; higher address bits are ignored and alias. row = dram_addr[ADDR_WIDTH+1:COL_BITS+2].
- A write updates mem[index] on its accept edge. A later read of the same index returns the new value. Memory contents are not reset.
- dram_nwait is combinational from state, dram_cs and row compare. There is no combinational path from dram_din or dram_we.
- FSM states:
  - IDLE: no row open. nwait = !cs. If cs: latch row, load counter=T_RCD, go to ACT.
  - ACT: nwait=0. Counter decrements each cycle; after exactly the loaded number of cycles, go to OPEN.
  - OPEN, cs=1 with row hit: nwait=1 (accept).
  - OPEN, cs=1 with row miss: nwait=0 that cycle; latch new row, counter=T_RP+T_RCD, go to ACT.
  - OPEN, cs=0: nwait=1, stay in OPEN.
  - REF: nwait=0 for T_RFC cycles, then go to IDLE (row closed).
- Refresh:
  - A free-running counter starts at 0 after reset and wraps at REF_PERIOD-1. On the wrap edge it sets refresh_due.
  - In IDLE or OPEN with refresh_due, refresh wins over any access: nwait = !cs. Pending read data is delivered only if cs=0. Next state is REF and refresh_due clears.
  - refresh_due set during ACT waits until the cycle after ACT reaches OPEN.
  - dram_dout holds its value through ACT and REF.
- Reset: state=IDLE, dram_dout=0, refresh counter=0, refresh_due=0, no open row. In the reset-release cycle with cs=0, dram_nwait=1.
- Reset asserted mid-burst or mid-refresh aborts the operation. Writes not yet accepted are not performed.
- Counters are sized to hold T_RP+T_RCD, T_RFC and REF_PERIOD-1 without overflow.
- Latency from row closed: 1+T_RCD cycles of nwait=0 before the first accept. Row miss: 1+T_RP+T_RCD. Sequential same-row accesses: zero wait.

Test Plan:
- Write burst: after reset (REF_PERIOD=64 on bench), write 0xA0,0xA1,0xA2,0xA3 to 0x100,0x104,0x108,0x10C with cs held from cycle 0 -> nwait=0 in cycles 0-2; accepts in cycles 3,4,5,6.
- Read burst: read 0x100-0x10C in the open row -> no wait states; dout=0xA0..0xA3 each one cycle after its accept; 0xA3 consumed on the following cs=0, nwait=1 cycle.
- Row miss: from OPEN on row 0x01, read 0x1000 (row 0x10) -> nwait=0 for 5 cycles; then dout returns the previously written value at that address.
- Refresh idle: REF_PERIOD=16, cs=0 -> nwait=1 in cycle 16; nwait=0 in cycles 17-20; IDLE in cycle 21; next access pays 1+T_RCD waits.
- Refresh colliding with a pending read: last read accepted in cycle 15, cs=1 in cycle 16 -> nwait=0 through REF+ACT; dout holds its value until the next nwait=1 edge.
- Reset mid-ACT: rst=1 for one cycle -> next cycle IDLE, dout=0, nwait=1 with cs=0; a prior unaccepted write leaves memory unchanged.
